// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, sequencer state encoding and instruction field positions
// shared by the control sequencer and its PC sub-module.
package ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int OP_LSB   = 12;
    localparam int Q0_LSB   = 8;
    localparam int Q1_LSB   = 4;
    localparam int DEST_LSB = 0;
    function automatic logic [3:0] field(input logic [15:0] ir, input int lsb);
        return ir[lsb +: 4];
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction-memory fetch bus (request/address out, ack/data back).
interface control_sequencer_if #(parameter int ADDR_W = 12);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_data;
    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/seq_pc.sv
// seq_pc: program counter with increment (wrapping at 2^ADDR_W), jump load and sync reset.
module seq_pc #(parameter int ADDR_W = 12) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    always_comb pc_d = load_i ? load_val_i : inc_i ? pc_q + 1'b1 : pc_q;
    always_ff @(posedge clk) pc_q <= rst ? '0 : pc_d;
    assign pc_o = pc_q;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/exec/writeback sequencer for a 16-bit instruction stream.
// Define SEQ_JUMP_EN to make opcode 0xE a PC jump; otherwise 0xE behaves as NOP.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    control_sequencer_if.master        imem,
    output logic [3:0]                 rf_raddr0,
    output logic [3:0]                 rf_raddr1,
    output logic [3:0]                 alu_op,
    output logic                       rf_we,
    output logic [3:0]                 rf_waddr,
    output logic [ADDR_W-1:0]          pc,
    output logic                       halted
);
    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        pc_inc, pc_load;
    logic [3:0]  op;
    assign op = field(ir_q, OP_LSB);
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH: if (imem.imem_ack) begin
                ir_d    = imem.imem_data;
                pc_inc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
`ifdef SEQ_JUMP_EN
                pc_load = op == OP_JMP;
`endif
                state_d = (op == OP_NOP || op == OP_JMP) ? S_FETCH : op == OP_HLT ? S_HALT : S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end
    // Jump target is the low ADDR_W bits of the 12-bit Q0/Q1/DEST immediate.
    seq_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (ir_q[ADDR_W-1:0]),
        .pc_o       (pc)
    );
    assign imem.imem_req  = state_q == S_FETCH;
    assign imem.imem_addr = pc;
    assign rf_we          = state_q == S_WB;
    assign halted         = state_q == S_HALT;
    assign alu_op         = op;
    assign rf_raddr0      = field(ir_q, Q0_LSB);
    assign rf_raddr1      = field(ir_q, Q1_LSB);
    assign rf_waddr       = field(ir_q, DEST_LSB);
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed literal checks plus randomized run against an instruction-level model.
module tb_control_sequencer;
    import ctrl_pkg::*;
    localparam int AW = 12;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_WB = 4, P_HALT = 5;

    logic clk = 1'b0;
    logic rst, run, run4;
    logic [3:0] rf_raddr0, rf_raddr1, alu_op, rf_waddr;
    logic rf_we, halted;
    logic [AW-1:0] pc;
    logic [3:0] d_r0, d_r1, d_op, d_wa;
    logic d_we, d_halt;
    logic [3:0] pc4;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    control_sequencer_if #(.ADDR_W(AW)) bus ();
    control_sequencer_if #(.ADDR_W(4))  bus4 ();
    assign bus4.imem_ack  = bus4.imem_req;
    assign bus4.imem_data = 16'h0000;

    control_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .run(run), .imem(bus.master),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .alu_op(alu_op),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .pc(pc), .halted(halted)
    );
    control_sequencer #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run4), .imem(bus4.master),
        .rf_raddr0(d_r0), .rf_raddr1(d_r1), .alu_op(d_op),
        .rf_we(d_we), .rf_waddr(d_wa), .pc(pc4), .halted(d_halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Instruction-level reference: phase, PC and IR advanced from the sampled inputs.
    int ph = P_IDLE;
    logic [AW-1:0] mpc = '0;
    logic [15:0] mir = '0;
    bit mvalid = 1'b0;
    int mop;
    always @(posedge clk) begin
        if (rst) begin
            ph = P_IDLE; mpc = '0; mir = '0; mvalid = 1'b1;
        end else if (ph == P_IDLE) begin
            if (run) ph = P_FETCH;
        end else if (ph == P_FETCH) begin
            if (bus.imem_ack) begin
                mir = bus.imem_data; mpc = mpc + 1'b1; ph = P_DEC;
            end
        end else if (ph == P_DEC) begin
            ph = P_EXEC;
        end else if (ph == P_EXEC) begin
            mop = int'(mir[15:12]);
            if (mop == 15) ph = P_HALT;
            else if (mop == 0) ph = P_FETCH;
            else if (mop == 14) begin
`ifdef SEQ_JUMP_EN
                mpc = mir[AW-1:0];
`endif
                ph = P_FETCH;
            end else ph = P_WB;
        end else if (ph == P_WB) begin
            ph = P_FETCH;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_req", bus.imem_req, ph == P_FETCH);
            chk("m_addr", bus.imem_addr, mpc);
            chk("m_pc", pc, mpc);
            chk("m_we", rf_we, ph == P_WB);
            chk("m_halted", halted, ph == P_HALT);
            if (ph == P_DEC || ph == P_EXEC || ph == P_IDLE) begin
                chk("m_raddr0", rf_raddr0, mir[11:8]);
                chk("m_raddr1", rf_raddr1, mir[7:4]);
            end
            if (ph == P_EXEC || ph == P_WB || ph == P_IDLE) chk("m_alu_op", alu_op, mir[15:12]);
            if (ph == P_WB || ph == P_IDLE) chk("m_waddr", rf_waddr, mir[3:0]);
        end
    end

    logic [31:0] w;
    logic [AW-1:0] jmp_exp;
    int req_cycles;
    bit found;

    initial begin
        rst = 1'b1; run = 1'b0; run4 = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_data = 16'h0000;
        tick();
        rst = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_fields", {alu_op, rf_raddr0, rf_raddr1, rf_waddr}, 0);

        // ALU instruction acked in the first FETCH cycle
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t1_fetch_req", bus.imem_req, 1);
        chk("t1_fetch_addr", bus.imem_addr, 0);
        bus.imem_ack = 1'b1; bus.imem_data = 16'h1234;
        tick();
        bus.imem_ack = 1'b0;
        chk("t1_raddr0", rf_raddr0, 2);
        chk("t1_raddr1", rf_raddr1, 3);
        chk("t1_pc", pc, 1);
        tick();
        chk("t1_alu_op", alu_op, 1);
        chk("t1_exec_we", rf_we, 0);
        tick();
        chk("t1_wb_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 4);
        tick();
        chk("t1_we_drop", rf_we, 0);
        chk("t1_refetch", bus.imem_req, 1);

        // ack three cycles late
        req_cycles = 0;
        bus.imem_data = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            req_cycles += int'(bus.imem_req);
            chk("t2_addr_stable", bus.imem_addr, 1);
            chk("t2_ir_hold", dut.ir_q, 16'h1234);
            tick();
        end
        req_cycles += int'(bus.imem_req);
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        chk("t2_req_cycles", req_cycles, 4);
        chk("t2_ir_load", dut.ir_q, 16'h5678);
        chk("t2_req_drop", bus.imem_req, 0);
        chk("t2_pc", pc, 2);
        tick(); tick(); tick();

        // opcode 0xE
        chk("t3_fetch_addr", bus.imem_addr, 2);
        bus.imem_ack = 1'b1; bus.imem_data = 16'hE0AB;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        chk("t3_exec_we", rf_we, 0);
        tick();
`ifdef SEQ_JUMP_EN
        jmp_exp = 12'h0AB;
`else
        jmp_exp = 12'h003;
`endif
        chk("t3_next_addr", bus.imem_addr, jmp_exp);
        chk("t3_no_we", rf_we, 0);
        chk("t3_refetch", bus.imem_req, 1);

        // halt, then ignore run and ack until reset
        bus.imem_ack = 1'b1; bus.imem_data = 16'hF000;
        tick();
        bus.imem_ack = 1'b0;
        tick(); tick();
        chk("t4_halted", halted, 1);
        run = 1'b1; bus.imem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_halt_req", bus.imem_req, 0);
            chk("t4_halt_flag", halted, 1);
        end
        rst = 1'b1; bus.imem_ack = 1'b0;
        tick();
        rst = 1'b0; run = 1'b0;
        chk("t4_state", dut.state_q, S_IDLE);
        chk("t4_pc", pc, 0);
        chk("t4_unhalt", halted, 0);

        // reset mid-FETCH with a simultaneous ack
        run = 1'b1;
        tick();
        chk("t5_fetch_req", bus.imem_req, 1);
        rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_data = 16'h1234;
        tick();
        rst = 1'b0; bus.imem_ack = 1'b0; run = 1'b0;
        chk("t5_ir", dut.ir_q, 0);
        chk("t5_req", bus.imem_req, 0);
        chk("t5_state", dut.state_q, S_IDLE);
        chk("t5_pc", pc, 0);

        // ADDR_W=4 instance: PC wraps from 15 to 0
        run4 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (pc4 == 4'd15 && bus4.imem_req) found = 1'b1;
            else tick();
        end
        chk("t6_reach_15", found, 1);
        tick();
        chk("t6_wrap_pc", pc4, 0);
        run4 = 1'b0;

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            rst = halted || ($urandom_range(0, 299) == 0);
            run = 1'($urandom_range(0, 1));
            bus.imem_ack = $urandom_range(0, 2) == 0;
            w = $urandom;
            if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h1;
            bus.imem_data = w[15:0];
            tick();
        end
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, program counter and instruction-memory address width (legal range 4..12).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port run  input  1  start request, sampled in IDLE.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  ADDR_W  fetch address, equal to PC.
REQ-007 SHALL have port imem_ack  input  1  fetch complete; imem_data valid this cycle.
REQ-008 SHALL have port imem_data  input  16  instruction word: [15:12] OP, [11:8] Q0, [7:4] Q1, [3:0] DEST.
REQ-009 SHALL have port rf_raddr0  output  4  register-file read address 0, from Q0.
REQ-010 SHALL have port rf_raddr1  output  4  register-file read address 1, from Q1.
REQ-011 SHALL have port alu_op  output  4  ALU operation, from OP.
REQ-012 SHALL have port rf_we  output  1  register-file write enable.
REQ-013 SHALL have port rf_waddr  output  4  write address, from DEST.
REQ-014 SHALL have port pc  output  ADDR_W  current program counter.
REQ-015 SHALL have port halted  output  1  high while in HALT.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, WB and HALT, and SHALL hold a 16-bit instruction register (IR).
REQ-017 SHALL, in IDLE, move to FETCH when run=1 and stay in IDLE otherwise.
REQ-018 SHALL, in FETCH, hold imem_req=1 until imem_ack=1; on ack: IR<=imem_data, PC<=PC+1 modulo 2^ADDR_W (max wraps to 0), next state DECODE.
REQ-019 SHALL ignore imem_ack in every state other than FETCH.
REQ-020 SHALL, in DECODE, drive rf_raddr0=IR[11:8] and rf_raddr1=IR[7:4]; next state EXEC.
REQ-021 SHALL, in EXEC, drive alu_op=IR[15:12] and keep the read addresses stable.
REQ-022 SHALL use the following EXEC transitions by opcode.
- OP 0x0 (NOP): go to FETCH.
- OP 0x1..0xD (ALU): go to WB.
- OP 0xE (JMP): see REQ-030 and REQ-031.
- OP 0xF (HLT): go to HALT.
REQ-023 SHALL, in WB, assert rf_we=1 for exactly one cycle with rf_waddr=IR[3:0] and alu_op held; next state FETCH.
REQ-024 SHALL keep rf_we=0 in every state except WB.
REQ-025 SHALL keep HALT until rst, with halted=1, imem_req=0 and run ignored.
REQ-026 SHALL give a 4-cycle ALU-instruction latency when imem_ack arrives in the first FETCH cycle: FETCH, DECODE, EXEC, WB.
REQ-027 SHALL extend FETCH by one cycle for each cycle that imem_ack is late; nothing else is stalled.

Reset
REQ-028 SHALL on rst=1 set, at the next edge and from any state (including mid-FETCH with imem_req high):
- state IDLE, PC=0, IR=0
- imem_req=0, rf_we=0, halted=0
- alu_op, rf_raddr0, rf_raddr1 and rf_waddr all 0
REQ-029 SHALL give rst priority over run and imem_ack in the same cycle.

Configuration
REQ-030 SHALL, with SEQ_JUMP_EN defined, treat OP 0xE in EXEC as a jump: PC<=IR[11:0] truncated to ADDR_W, next state FETCH, no WB.
REQ-031 SHALL, without SEQ_JUMP_EN, treat OP 0xE exactly as NOP: PC unchanged by EXEC, next state FETCH.

Structure
REQ-032 SHALL place opcode constants (OP_NOP=0x0, OP_JMP=0xE, OP_HLT=0xF), the state encoding and the instruction field bit positions in shared package ctrl_pkg.
REQ-033 SHALL implement the PC (increment, wrap, jump load, reset) as sub-module seq_pc; the FSM and IR stay in control_sequencer.

Verification
REQ-034 SHALL verify: rst, then run=1 with imem_data=16'h1234 and ack in the first FETCH cycle -> DECODE raddr0=2/raddr1=3; EXEC alu_op=1; WB rf_we=1 for 1 cycle, rf_waddr=4; pc=1.
REQ-035 SHALL verify: imem_ack delayed 3 cycles -> imem_req high for 4 cycles, imem_addr stable, IR loaded only on the ack cycle.
REQ-036 SHALL verify: instruction 16'hF000 -> halted=1 after EXEC, imem_req stays 0 for 20 cycles with run=1; rst -> IDLE, pc=0.
REQ-037 SHALL verify: 16'hE0AB with SEQ_JUMP_EN -> next imem_addr=0x0AB, no rf_we; without the macro -> next imem_addr=previous PC+1, no rf_we.
REQ-038 SHALL verify: ADDR_W=4, PC=15, fetch acked -> pc=0.
REQ-039 SHALL verify: rst asserted mid-FETCH with imem_ack=1 in the same cycle -> IR stays 0, imem_req=0 next cycle, state IDLE.
